data_cache: RTL and testbench

Direct-mapped, write-back data cache for the RV32IM pipeline's MEM stage. It answers load/store requests from the EX/MEM stage and drives the data-memory BUSYWAIT that freezes the pipeline registers, including MEM/WB, while a miss is being serviced. It performs RV32 byte/half/word load extraction with sign/zero extension and store merging. It talks to a 128-bit-block main memory over a busywait handshake.

---
 rtl/data_cache.sv | 174 +++++++++++++++++
 tb/tb_data_cache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// ----------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-back data cache for the MEM stage of the RV32IM
// pipeline. Eight lines of 16-byte blocks with a 25-bit tag. It performs
// RV32 load extraction with sign/zero extension and store merging, and it
// raises BUSYWAIT to freeze the pipeline while a miss is serviced.
//
// Ports:
//   CLK, RESET        clock; asynchronous active-high reset
//   READ, WRITE       load / store request (both high = store)
//   FUNCT3            RV32 load/store funct3
//   ADDRESS           byte address: tag[31:7], index[6:4], offset[3:0]
//   WRITEDATA         store data (low bits used for SB/SH)
//   READDATA          extended load result (0 when READ is low)
//   BUSYWAIT          pipeline stall request
//   MEM_READ          block fetch request to main memory
//   MEM_WRITE         block write-back request to main memory
//   MEM_ADDRESS       block address {tag,index}
//   MEM_WRITEDATA     victim block being written back
//   MEM_READDATA      block returned by main memory
//   MEM_BUSYWAIT      high while main memory is servicing a request
// ----------------------------------------------------------------------------
module data_cache (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [2:0]   FUNCT3,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t         state;

    logic [7:0]     valid;
    logic [7:0]     dirty;
    logic [24:0]    tags  [8];
    logic [127:0]   data  [8];

    logic [2:0]     index;
    logic [24:0]    tag_in;
    logic           hit;
    logic [127:0]   line_data;
    logic [31:0]    cur_word;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    store_word;
    logic           store_en;
    logic           store_hit;
    logic           request;

    assign index     = ADDRESS[6:4];
    assign tag_in    = ADDRESS[31:7];
    assign line_data = data[index];
    assign hit       = valid[index] && (tags[index] == tag_in);
    assign request   = READ || WRITE;

    assign cur_word  = line_data[{ADDRESS[3:2], 5'b00000} +: 32];
    assign byte_sel  = cur_word[{ADDRESS[1:0], 3'b000} +: 8];
    assign half_sel  = cur_word[{ADDRESS[1], 4'b0000} +: 16];

    assign BUSYWAIT  = (request && !((state == IDLE) && hit)) || (state != IDLE);

    // Load extraction
    always_comb begin
        READDATA = '0;
        if (READ) begin
            case (FUNCT3)
                3'b000:  READDATA = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  READDATA = {{16{half_sel[15]}}, half_sel};
                3'b010:  READDATA = cur_word;
                3'b100:  READDATA = {24'h000000, byte_sel};
                3'b101:  READDATA = {16'h0000, half_sel};
                default: READDATA = '0;
            endcase
        end
    end

    // Store merging into the currently addressed word
    always_comb begin
        store_word = cur_word;
        store_en   = 1'b1;
        case (FUNCT3)
            3'b000:  store_word[{ADDRESS[1:0], 3'b000} +: 8] = WRITEDATA[7:0];
            3'b001:  store_word[{ADDRESS[1], 4'b0000} +: 16] = WRITEDATA[15:0];
            3'b010:  store_word = WRITEDATA;
            default: store_en = 1'b0;
        endcase
    end

    assign store_hit = WRITE && hit && (state == IDLE) && store_en;

    // Tag and data arrays carry no reset. During reset the FSM is held in
    // IDLE with every valid bit clear, so neither write condition can fire.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data[index] <= MEM_READDATA;
            tags[index] <= tag_in;
        end else if (store_hit) begin
            data[index][{ADDRESS[3:2], 5'b00000} +: 32] <= store_word;
        end
    end

    // Miss-handling FSM with registered memory-side outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit) begin
                        dirty[index] <= 1'b1;
                    end else if (request && !hit) begin
                        if (valid[index] && dirty[index]) begin
                            state         <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tags[index], index};
                            MEM_WRITEDATA <= line_data;
                        end else begin
                            state       <= FETCH;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= ADDRESS[31:4];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state       <= FETCH;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= ADDRESS[31:4];
                    end
                end
                FETCH: begin
                    // MEM_ADDRESS is kept through UPDATE so the returned
                    // block stays addressed while it is written in.
                    if (!MEM_BUSYWAIT) begin
                        state    <= UPDATE;
                        MEM_READ <= 1'b0;
                    end
                end
                UPDATE: begin
                    valid[index] <= 1'b1;
                    dirty[index] <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic         WRITE;
    logic [2:0]   FUNCT3;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int errors = 0;
    int checks = 0;
    int K = 4;
    int cnt = 0;

    logic [127:0] mem [256];
    logic [255:0] wr_valid = '0;
    logic         overlap_seen = 1'b0;

    // Scoreboards: expected entries pushed with the stimulus,
    // observed memory transactions pushed by the memory model.
    logic [159:0] exp_mem_q [$];
    logic [159:0] obs_mem_q [$];
    logic [31:0]  exp_rd_q  [$];

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .FUNCT3        (FUNCT3),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Default memory contents: word w of block a = {C0DE, a[11:0], w}
    function automatic logic [127:0] pat(input logic [27:0] a);
        logic [127:0] r;
        r = '0;
        for (int unsigned w = 0; w < 4; w++) begin
            r[32*w +: 32] = {16'hC0DE, a[11:0], w[3:0]};
        end
        return r;
    endfunction

    // Main memory model: busy for K cycles, completes on the following edge
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < K);
    assign MEM_READDATA = wr_valid[MEM_ADDRESS[7:0]] ? mem[MEM_ADDRESS[7:0]] : pat(MEM_ADDRESS);

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (cnt < K) begin
                cnt <= cnt + 1;
            end else begin
                cnt <= 0;
                obs_mem_q.push_back({3'b000, MEM_WRITE, MEM_ADDRESS,
                                     MEM_WRITE ? MEM_WRITEDATA : MEM_READDATA});
                if (MEM_WRITE) begin
                    mem[MEM_ADDRESS[7:0]]      <= MEM_WRITEDATA;
                    wr_valid[MEM_ADDRESS[7:0]] <= 1'b1;
                end
            end
        end else begin
            cnt <= 0;
        end
    end

    always @(negedge CLK) begin
        if (MEM_READ && MEM_WRITE) overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request and wait for BUSYWAIT to drop; compare stall length,
    // load data and memory traffic against the scoreboards.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_stall, input string tag);
        int stall;
        logic [159:0] e;
        logic [159:0] o;
        logic [31:0]  erd;
        @(negedge CLK);
        READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITEDATA = wdata;
        #1;
        stall = 0;
        while (BUSYWAIT && stall < 200) begin
            stall++;
            @(negedge CLK);
            #1;
        end
        check($sformatf("%s_stall", tag), 160'(stall), 160'(exp_stall));
        if (rd && !wr) begin
            erd = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 32'hxxxx_xxxx;
            check($sformatf("%s_data", tag), 160'(READDATA), 160'(erd));
        end
        while (exp_mem_q.size() > 0) begin
            e = exp_mem_q.pop_front();
            o = (obs_mem_q.size() > 0) ? obs_mem_q.pop_front() : '0;
            check($sformatf("%s_memtx", tag), o, e);
        end
        check($sformatf("%s_no_extra_tx", tag), 160'(obs_mem_q.size()), 160'(0));
    endtask

    initial begin
        logic [127:0] blk4;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; FUNCT3 = 3'b000;
        ADDRESS = '0; WRITEDATA = '0;
        #12;
        check("reset_outputs", 160'({BUSYWAIT, MEM_READ, MEM_WRITE, READDATA, MEM_ADDRESS}), 160'(0));
        check("reset_wdata", 160'(MEM_WRITEDATA), 160'(0));
        @(negedge CLK);
        RESET = 1'b0;

        // Clean miss with K=4: 1 IDLE + 5 FETCH + 1 UPDATE
        K = 4;
        exp_mem_q.push_back({3'b000, 1'b0, 28'h0000004, pat(28'h4)});
        exp_rd_q.push_back(32'hC0DE0040);
        access(1, 0, 3'b010, 32'h0000_0040, 0, 7, "lw40_miss");
        exp_rd_q.push_back(32'hC0DE0040);
        access(1, 0, 3'b010, 32'h0000_0040, 0, 0, "lw40_hit");

        // Store hit then sub-word loads
        access(0, 1, 3'b010, 32'h0000_0044, 32'hDEADBEEF, 0, "sw44");
        exp_rd_q.push_back(32'hFFFFFFEF);
        access(1, 0, 3'b000, 32'h0000_0044, 0, 0, "lb44");
        exp_rd_q.push_back(32'h000000DE);
        access(1, 0, 3'b100, 32'h0000_0047, 0, 0, "lbu47");
        exp_rd_q.push_back(32'hFFFFDEAD);
        access(1, 0, 3'b001, 32'h0000_0046, 0, 0, "lh46");
        exp_rd_q.push_back(32'h0000BEEF);
        access(1, 0, 3'b101, 32'h0000_0044, 0, 0, "lhu44");

        // Byte store merge; unsupported funct3 store must not modify
        access(0, 1, 3'b000, 32'h0000_0045, 32'hFFFF_FF12, 0, "sb45");
        access(0, 1, 3'b011, 32'h0000_0044, 32'h1111_1111, 0, "st_bad_f3");
        exp_rd_q.push_back(32'hDEAD12EF);
        access(1, 0, 3'b010, 32'h0000_0044, 0, 0, "lw44_merged");
        exp_rd_q.push_back(32'h0000_0000);
        access(1, 0, 3'b011, 32'h0000_0044, 0, 0, "ld_bad_f3");
        exp_rd_q.push_back(32'hC0DE0042);
        access(1, 0, 3'b010, 32'h0000_0048, 0, 0, "lw48_untouched");

        // Conflict miss with dirty victim: writeback then fetch, 2K+4 cycles
        blk4 = pat(28'h4);
        blk4[63:32] = 32'hDEAD12EF;
        exp_mem_q.push_back({3'b000, 1'b1, 28'h0000004, blk4});
        exp_mem_q.push_back({3'b000, 1'b0, 28'h000000C, pat(28'hC)});
        exp_rd_q.push_back(32'hC0DE00C1);
        access(1, 0, 3'b010, 32'h0000_00C4, 0, 12, "lwC4_dirty_miss");

        // Long memory latency then reset in the middle of FETCH
        K = 20;
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h0000_0044;
        #1;
        check("hold_req_busy", 160'(BUSYWAIT), 160'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            check($sformatf("hold_fetch_%0d", i),
                  160'({BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS}),
                  160'({1'b1, 1'b1, 1'b0, 28'h0000004}));
        end
        READ = 1'b0;
        RESET = 1'b1;
        #1;
        check("reset_abort", 160'({BUSYWAIT, MEM_READ, MEM_WRITE, READDATA}), 160'(0));
        @(negedge CLK);
        RESET = 1'b0;
        check("reset_abort_no_tx", 160'(obs_mem_q.size()), 160'(0));

        // Previously cached line must miss after reset
        K = 2;
        exp_mem_q.push_back({3'b000, 1'b0, 28'h000000C, pat(28'hC)});
        exp_rd_q.push_back(32'hC0DE00C1);
        access(1, 0, 3'b010, 32'h0000_00C4, 0, 5, "lwC4_after_reset");
        exp_rd_q.push_back(32'hC0DE00C3);
        access(1, 0, 3'b010, 32'h0000_00CC, 0, 0, "lwCC_hit");

        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
        #1;
        check("idle_outputs", 160'({BUSYWAIT, READDATA}), 160'(0));
        check("no_rw_overlap", 160'(overlap_seen), 160'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
